// File: rtl/pool_pkg.sv
// Shared definitions for the pooling frame sequencer and its cascaded instances.
package pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SOF   = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } pool_state_e;

  localparam int POOL_ADDR_W = 16;

  // Number of pooled output pixels for a w x h input frame (2x2 pooling).
  function automatic int n_out(input int w, input int h);
    return (w * h) / 4;
  endfunction

endpackage

// File: rtl/pool_rd_pipe.sv
// Read-return pipeline: tracks which cycles carry valid read data and
// registers that data towards the pooling engine.
module pool_rd_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       issue_i,
  input  logic [7:0] rd_data_i,
  output logic [7:0] pix_o,
  output logic       vld_o
);

  logic [RD_LAT-1:0] vld_pipe_q;
  logic [7:0]        pix_q;
  logic              vld_q;

  // Shift the issue marker along with the read latency; capture data at the tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      vld_q      <= 1'b0;
      pix_q      <= 8'd0;
    end else if (flush_i) begin
      vld_pipe_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      vld_pipe_q[0] <= issue_i;
      for (int i = 1; i < RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      vld_q <= vld_pipe_q[RD_LAT-1];
      if (vld_pipe_q[RD_LAT-1]) pix_q <= rd_data_i;
    end
  end

  assign pix_o = pix_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pool_seq_ctrl.sv
// Frame sequencer: streams one frame from the read port into the 2x2 pooling
// engine and writes the pooled pixels back out.
module pool_seq_ctrl
  import pool_pkg::*;
#(
  parameter int IN_WIDTH      = 112,
  parameter int IN_HEIGHT     = 112,
  parameter int ADDR_W        = POOL_ADDR_W,
  parameter int RD_LAT        = 2,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              rd_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              pool_frame_start,
  output logic [7:0]        pool_pixel,
  output logic              pool_valid,
  input  logic [7:0]        pool_out,
  input  logic              pool_out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int N_IN  = IN_WIDTH * IN_HEIGHT;
  localparam int N_OUT = n_out(IN_WIDTH, IN_HEIGHT);
  localparam int RC_W  = $clog2(N_IN + 1);
  localparam int OC_W  = $clog2(N_OUT + 1);
  localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);

  pool_state_e       state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [RC_W-1:0]   rd_cnt_q;
  logic [OC_W-1:0]   out_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              done_q, err_q, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  // Reads are issued combinationally so rd_en never asserts without rd_ready.
  assign rd_en   = (state_q == S_READ) && rd_ready;
  assign rd_addr = src_q + ADDR_W'(rd_cnt_q);

  assign busy             = (state_q != S_IDLE);
  assign pool_frame_start = (state_q == S_SOF);
  assign done             = done_q;
  assign err              = err_q;
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;

  pool_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (abort),
    .issue_i   (rd_en),
    .rd_data_i (rd_data),
    .pix_o     (pool_pixel),
    .vld_o     (pool_valid)
  );

  // Frame FSM with write path, completion and drain timeout; abort overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      to_cnt_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        if (state_q != S_IDLE && pool_out_valid) begin
          wr_en_q   <= 1'b1;
          wr_data_q <= pool_out;
          wr_addr_q <= dst_q + ADDR_W'(out_cnt_q);
          out_cnt_q <= out_cnt_q + OC_W'(1);
        end
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_SOF;
              src_q     <= src_base;
              dst_q     <= dst_base;
              err_q     <= 1'b0;
              rd_cnt_q  <= '0;
              out_cnt_q <= '0;
              to_cnt_q  <= '0;
            end
          end
          S_SOF: state_q <= S_READ;
          S_READ: begin
            if (rd_ready) begin
              rd_cnt_q <= rd_cnt_q + RC_W'(1);
              if (rd_cnt_q == RC_W'(N_IN - 1)) state_q <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (pool_out_valid) begin
              to_cnt_q <= '0;
              if (out_cnt_q == OC_W'(N_OUT - 1)) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end else if (to_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Bench for pool_seq_ctrl: frame memory, read-latency model, 2x2 max engine
// stub, and a reference that derives expected writes straight from memory.
module tb_pool_seq_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int LAT = 2;
  localparam int TO  = 16;
  localparam int NI  = W * H;
  localparam int NO  = NI / 4;

  logic        clk = 0, rst = 1;
  logic        start = 0, abort = 0;
  logic [15:0] src_base = 0, dst_base = 0;
  logic        busy, done, err;
  logic        rd_ready = 1, rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        pool_frame_start, pool_valid;
  logic [7:0]  pool_pixel;
  logic [7:0]  pool_out = 0;
  logic        pool_out_valid = 0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  pool_seq_ctrl #(.IN_WIDTH(W), .IN_HEIGHT(H), .ADDR_W(16), .RD_LAT(LAT),
                  .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .err(err),
    .rd_ready(rd_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_frame_start(pool_frame_start), .pool_pixel(pool_pixel),
    .pool_valid(pool_valid), .pool_out(pool_out), .pool_out_valid(pool_out_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- frame memory and fixed-latency read port ----------------
  logic [7:0] mem [0:65535];
  logic [7:0] rdp [0:LAT-1];
  assign rd_data = rdp[LAT-1];
  always @(posedge clk) begin
    rdp[0] <= rd_en ? mem[rd_addr] : 8'd0;
    for (int i = 1; i < LAT; i++) rdp[i] <= rdp[i-1];
  end

  int rdy_mode = 0, t_start = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rd_ready <= 1'b1;
      1:       rd_ready <= ((cyc - t_start) % 2 == 1);
      default: rd_ready <= ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- 2x2 max engine stub ----------------
  bit         eng_on = 1;
  int         ecnt = 0;
  logic [7:0] epx [0:NI-1];
  function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
  always @(posedge clk) begin
    pool_out_valid <= 1'b0;
    if (pool_frame_start) ecnt <= 0;
    else if (pool_valid && ecnt < NI) begin
      epx[ecnt] <= pool_pixel;
      ecnt <= ecnt + 1;
      if ((ecnt % W) % 2 == 1 && (ecnt / W) % 2 == 1) begin
        pool_out_valid <= eng_on;
        pool_out <= max4(epx[ecnt-W-1], epx[ecnt-W], epx[ecnt-1], pool_pixel);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] cur_src = 0;
  int rd_base = 0, wr_base = 0, exp_nwr = 0;
  logic [15:0] exp_wa [0:NO-1];
  logic [7:0]  exp_wd [0:NO-1];
  int nread_tot = 0, nwr_tot = 0, done_tot = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  bit         en_hist [0:7];
  bit         ab_hist [0:7];
  logic [7:0] px_hist [0:7];

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        chk("rd_en_needs_ready", rd_ready, 1);
        chk("rd_addr", rd_addr, 16'(cur_src + nread_tot - rd_base));
        nread_tot   <= nread_tot + 1;
        last_rd_cyc <= cyc;
      end
      if (wr_en) begin
        if (nwr_tot - wr_base < exp_nwr) begin
          chk("wr_addr", wr_addr, exp_wa[nwr_tot - wr_base]);
          chk("wr_data", wr_data, exp_wd[nwr_tot - wr_base]);
        end else chk("unexpected_write", 1, 0);
        nwr_tot     <= nwr_tot + 1;
        last_wr_cyc <= cyc;
      end
      if (done) begin
        done_tot <= done_tot + 1;
        done_cyc <= cyc;
      end
      // A read at c shows as pool_valid at c+LAT+1 unless abort fell in c..c+LAT.
      if (cyc > 8) begin
        if ((en_hist[(cyc-3)&7] && !ab_hist[(cyc-3)&7] && !ab_hist[(cyc-2)&7] &&
             !ab_hist[(cyc-1)&7]) || pool_valid) begin
          chk("pool_valid", pool_valid, en_hist[(cyc-3)&7] && !ab_hist[(cyc-3)&7] &&
              !ab_hist[(cyc-2)&7] && !ab_hist[(cyc-1)&7]);
          if (pool_valid) chk("pool_pixel", pool_pixel, px_hist[(cyc-3)&7]);
        end
      end
    end
    en_hist[cyc&7] <= rd_en && !rst;
    ab_hist[cyc&7] <= abort;
    px_hist[cyc&7] <= mem[rd_addr];
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    bit          rnd_data;
    int          rdy;
    bit          eng;
    bit          exp_err;
    int          exp_len;   // READ cycles, -1 = not checked
    int          dbl;       // cycle offset of a start pulse while busy, 0 = none
  } vec_t;
  vec_t tbl [10];

  task automatic setup_frame(input vec_t v);
    logic [7:0] m;
    logic [15:0] a;
    for (int i = 0; i < NI; i++)
      mem[16'(v.src + i)] = v.rnd_data ? 8'($urandom) : 8'(i);
    rdy_mode = v.rdy;
    eng_on   = v.eng;
    cur_src  = v.src;
    rd_base  = nread_tot;
    wr_base  = nwr_tot;
    exp_nwr  = v.eng ? NO : 0;
    for (int k = 0; k < NO; k++) begin
      m = 0;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          a = 16'(v.src + (2*(k/(W/2)) + dr) * W + 2*(k%(W/2)) + dc);
          if (mem[a] > m) m = mem[a];
        end
      exp_wd[k] = m;
      exp_wa[k] = 16'(v.dst + k);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int dn0, guard;
    setup_frame(v);
    dn0 = done_tot;
    @(posedge clk); #1;
    start = 1; src_base = v.src; dst_base = v.dst; t_start = cyc;
    @(posedge clk); #1;
    start = 0; src_base = 16'h3000; dst_base = 16'h3100;
    @(negedge clk);
    chk("sof_busy", busy, 1);
    chk("sof_frame_start", pool_frame_start, 1);
    chk("start_clears_err", err, 0);
    guard = 0;
    while (done_tot == dn0 && guard < 400) begin
      @(posedge clk); #1;
      start = (v.dbl != 0 && cyc == t_start + v.dbl);
      guard++;
    end
    start = 0;
    if (guard >= 400) chk("frame_timeout", 0, 1);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("err_flag", err, v.exp_err);
    chk("n_reads", nread_tot - rd_base, NI);
    chk("n_writes", nwr_tot - wr_base, exp_nwr);
    if (v.exp_len > 0) chk("read_len", last_rd_cyc - t_start - 1, v.exp_len);
    if (v.eng) chk("done_with_last_wr", done_cyc, last_wr_cyc);
    else       chk("timeout_done_cyc", done_cyc, last_rd_cyc + 1 + TO);
    repeat (3) @(posedge clk);
    chk("single_done", done_tot - dn0, 1);
  endtask

  initial begin
    int dn0, nr0, nw0, t0;
    tbl[0] = '{16'h0100, 16'h0200, 0, 0, 1, 0, 16, 0};
    tbl[1] = '{16'h0100, 16'h0200, 0, 1, 1, 0, 32, 0};
    tbl[2] = '{16'h0100, 16'h0200, 0, 0, 0, 1, 16, 0};
    tbl[3] = '{16'h0100, 16'h0200, 0, 0, 1, 0, 16, 0};
    tbl[4] = '{16'hFFFE, 16'hFFFE, 1, 0, 1, 0, 16, 0};
    tbl[5] = '{16'h0100, 16'h0200, 0, 0, 1, 0, 16, 6};
    for (int i = 6; i < 10; i++)
      tbl[i] = '{16'($urandom), 16'($urandom), 1, 2, 1, 0, -1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, err, rd_en, rd_addr, pool_frame_start, pool_pixel,
                          pool_valid, wr_en, wr_addr, wr_data}, 0);
    @(posedge clk); #1 rst = 0;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 10; i++) run_frame(tbl[i]);

    // abort mid-READ while rd_cnt = 7
    setup_frame(tbl[0]);
    exp_nwr = 0;
    dn0 = done_tot;
    @(posedge clk); #1;
    start = 1; src_base = 16'h0100; dst_base = 16'h0200; t0 = cyc;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    #1 abort = 1;
    @(negedge clk);
    chk("abort_at_cnt7", rd_addr, 16'h0107);
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_rd_en_low", rd_en, 0);
    repeat (LAT) @(negedge clk);
    chk("abort_pool_valid_low", pool_valid, 0);
    repeat (20) @(posedge clk);
    chk("abort_no_done", done_tot - dn0, 0);
    chk("abort_no_write", nwr_tot - wr_base, 0);
    run_frame(tbl[0]);

    // start together with abort in IDLE is dropped
    nr0 = nread_tot; nw0 = nwr_tot; dn0 = done_tot;
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);
    repeat (25) @(posedge clk);
    chk("start_abort_no_reads", nread_tot - nr0, 0);
    chk("start_abort_no_done", done_tot - dn0, 0);
    chk("start_abort_no_writes", nwr_tot - nw0, 0);
    run_frame(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
